data_bus_master: RTL

- Load/store-unit side master for the data bus; drives the 3-slave data bus address decoder directly.
- Converts single-beat, blocking CPU load/store requests into AXI-lite-style AW/W/B and AR/R transactions.
- Holds address and control stable for the whole transaction, because slave routing is decoded combinationally from AWADDR/ARADDR.
- Returns a one-cycle completion pulse with data and error status. A timeout bounds accesses to unmapped regions, which never assert READY.

---
 rtl/data_bus_master_pkg.sv | 25 ++
 rtl/dbm_timeout_ctr.sv | 33 +++
 rtl/data_bus_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_master_pkg.sv
// Shared widths, response/protection constants and FSM state encoding for the data bus master.
package data_bus_master_pkg;

  localparam int unsigned DBM_ADDR_W  = 32;
  localparam int unsigned DBM_DATA_W  = 32;
  localparam int unsigned DBM_TIMEOUT = 255;

  localparam logic [2:0] RESP_OKAY    = 3'b000;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // One-hot state encoding.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WR_REQ  = 6'b000010,
    ST_WR_RESP = 6'b000100,
    ST_RD_ADDR = 6'b001000,
    ST_RD_DATA = 6'b010000,
    ST_DONE    = 6'b100000
  } dbm_state_e;

  function automatic logic resp_is_err(input logic [2:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/dbm_timeout_ctr.sv
// Saturating 8-bit transaction timer; flags the cycle in which the running count reaches LIMIT.
module dbm_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [8:0] LIMIT_9 = 9'(LIMIT);

  logic [7:0] r_count;
  logic [8:0] w_count_inc;

  assign w_count_inc = {1'b0, r_count} + 9'd1;

  // Count busy cycles, holding at LIMIT so the flag stays raised after a late handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && ({1'b0, r_count} != LIMIT_9)) begin
      r_count <= w_count_inc[7:0];
    end
  end

  // The count includes the current cycle, so the first transaction cycle counts as 1.
  assign o_expired = i_en && (w_count_inc >= LIMIT_9);

endmodule

// File: rtl/data_bus_master.sv
// Load/store-unit data bus master: one blocking CPU access becomes an AW/W/B or AR/R transaction.
module data_bus_master
  import data_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = DBM_ADDR_W,
  parameter int unsigned DATA_W  = DBM_DATA_W,
  parameter int unsigned TIMEOUT = DBM_TIMEOUT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  MemReq,
  input  logic                  MemWe,
  input  logic [ADDR_W-1:0]     MemAddr,
  input  logic [DATA_W-1:0]     MemWData,
  input  logic [DATA_W/8-1:0]   MemWStrb,
  output logic                  MemBusy,
  output logic                  MemDone,
  output logic [DATA_W-1:0]     MemRData,
  output logic                  MemErr,
  output logic                  AWVALID,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [2:0]            AWPROT,
  input  logic                  AWREADY,
  output logic                  WVALID,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WREADY,
  input  logic                  BVALID,
  input  logic [2:0]            BRESP,
  output logic                  BREADY,
  output logic                  ARVALID,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic [2:0]            ARPROT,
  input  logic                  ARREADY,
  input  logic                  RVALID,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [2:0]            RRESP,
  output logic                  RREADY
);

  dbm_state_e r_state, w_state_nxt;

  logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                r_busy, r_done, r_err;
  logic [ADDR_W-1:0]   r_awaddr, r_araddr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [DATA_W/8-1:0] r_wstrb;

  logic                w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_arvalid_nxt, w_rready_nxt;
  logic                w_busy_nxt, w_err_nxt, w_abort;
  logic [ADDR_W-1:0]   w_awaddr_nxt, w_araddr_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt, w_rdata_nxt;
  logic [DATA_W/8-1:0] w_wstrb_nxt;

  logic w_ctr_clr, w_ctr_en, w_expired;
  logic w_aw_fire, w_w_fire;

  assign w_aw_fire = r_awvalid && AWREADY;
  assign w_w_fire  = r_wvalid && WREADY;
  assign w_ctr_en  = (r_state != ST_IDLE) && (r_state != ST_DONE);

  dbm_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .i_clk     (Clk),
    .i_rst_n   (Rst),
    .i_clr     (w_ctr_clr),
    .i_en      (w_ctr_en),
    .o_expired (w_expired)
  );

  // State register and all bus-facing registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= ST_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= (w_state_nxt == ST_DONE);
      r_err     <= w_err_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_araddr  <= w_araddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  // Next-state and next-output decode; registers hold unless a handshake or timeout moves them.
  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_busy_nxt    = r_busy;
    w_awaddr_nxt  = r_awaddr;
    w_araddr_nxt  = r_araddr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = 1'b0;
    w_ctr_clr     = 1'b0;
    w_abort       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (MemReq) begin
          w_busy_nxt = 1'b1;
          w_ctr_clr  = 1'b1;
          if (MemWe) begin
            w_state_nxt   = ST_WR_REQ;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_awaddr_nxt  = MemAddr;
            w_wdata_nxt   = MemWData;
            w_wstrb_nxt   = MemWStrb;
          end else begin
            w_state_nxt   = ST_RD_ADDR;
            w_arvalid_nxt = 1'b1;
            w_araddr_nxt  = MemAddr;
          end
        end
      end
      ST_WR_REQ: begin
        if (w_aw_fire) w_awvalid_nxt = 1'b0;
        if (w_w_fire)  w_wvalid_nxt  = 1'b0;
        if ((!r_awvalid || w_aw_fire) && (!r_wvalid || w_w_fire)) begin
          w_state_nxt  = ST_WR_RESP;
          w_bready_nxt = 1'b1;
        end else if (w_expired) begin
          w_abort = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (r_bready && BVALID) begin
          w_bready_nxt = 1'b0;
          w_err_nxt    = resp_is_err(BRESP);
          w_state_nxt  = ST_DONE;
        end else if (w_expired) begin
          w_abort = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (r_arvalid && ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_RD_DATA;
        end else if (w_expired) begin
          w_abort = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (r_rready && RVALID) begin
          w_rready_nxt = 1'b0;
          w_rdata_nxt  = RDATA;
          w_err_nxt    = resp_is_err(RRESP);
          w_state_nxt  = ST_DONE;
        end else if (w_expired) begin
          w_abort = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_busy_nxt    = 1'b0;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
        w_arvalid_nxt = 1'b0;
        w_rready_nxt  = 1'b0;
      end
    endcase

    // Timeout only fires when no completing handshake was taken in the same cycle.
    if (w_abort) begin
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_bready_nxt  = 1'b0;
      w_arvalid_nxt = 1'b0;
      w_rready_nxt  = 1'b0;
      w_err_nxt     = 1'b1;
      w_rdata_nxt   = '0;
      w_state_nxt   = ST_DONE;
    end

    // Decoder routes on AWADDR/ARADDR, so they stay put until the transaction is finished.
    if (w_state_nxt == ST_DONE) begin
      w_awaddr_nxt = '0;
      w_araddr_nxt = '0;
      w_wdata_nxt  = '0;
      w_wstrb_nxt  = '0;
    end
  end

  assign MemBusy  = r_busy;
  assign MemDone  = r_done;
  assign MemErr   = r_err;
  assign MemRData = r_rdata;
  assign AWVALID  = r_awvalid;
  assign AWADDR   = r_awaddr;
  assign AWPROT   = PROT_DEFAULT;
  assign WVALID   = r_wvalid;
  assign WDATA    = r_wdata;
  assign WSTRB    = r_wstrb;
  assign BREADY   = r_bready;
  assign ARVALID  = r_arvalid;
  assign ARADDR   = r_araddr;
  assign ARPROT   = PROT_DEFAULT;
  assign RREADY   = r_rready;

endmodule
